ring_freq_meter: RTL



---
 rtl/ring_meter_pkg.sv | 18 +
 rtl/ring_sync_edge.sv | 25 ++
 rtl/ring_freq_meter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ring_meter_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
package ring_meter_pkg;

  localparam int unsigned GATE_BASE_LOG2 = 8;
  localparam int unsigned GATE_CNT_W     = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_DONE = 2'd2
  } meter_state_e;

  // Gate counter preload: window length 2^(8+sel) minus one.
  function automatic logic [GATE_CNT_W-1:0] gate_load(input logic [1:0] sel);
    return GATE_CNT_W'((32'd1 << (GATE_BASE_LOG2 + 32'(sel))) - 32'd1);
  endfunction

endpackage

// File: rtl/ring_sync_edge.sv
// Three-flop synchronizer for the asynchronous ring signal plus rising-edge detect.
module ring_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_c
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_c = s2 & ~s3;

endmodule

// File: rtl/ring_freq_meter.sv
// Gated edge-count frequency meter for the divided ring oscillator.
// Build option: RING_FREQ_METER_AUTORUN_EN selects free-running measurement.
module ring_freq_meter
  import ring_meter_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             ring_in,
  input  logic [1:0]       gate_sel,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic ring_edge_c;
  logic launch_c;

  meter_state_e          state_q, state_d;
  logic [GATE_CNT_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]      edge_cnt_q, edge_cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_d, done_d, overflow_d;
  logic [CNT_W-1:0]      count_d;

  ring_sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ring_in),
    .edge_c   (ring_edge_c)
  );

`ifdef RING_FREQ_METER_AUTORUN_EN
  logic unused_start;
  assign unused_start = start;
  assign launch_c     = 1'b1;
`else
  assign launch_c = start;
`endif

  // Next-state, counters and next registered outputs.
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    count_d    = count;
    overflow_d = overflow;

    case (state_q)
      ST_IDLE: begin
        if (launch_c) begin
          state_d    = ST_GATE;
          gate_cnt_d = gate_load(gate_sel);
          edge_cnt_d = '0;
          ovf_d      = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_GATE: begin
        busy_d = 1'b1;
        if (ring_edge_c) begin
          if (edge_cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                       edge_cnt_d = edge_cnt_q + CNT_W'(1);
        end
        // Last counted cycle: publish including this cycle's edge.
        if (gate_cnt_q == '0) begin
          state_d    = ST_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          count_d    = edge_cnt_d;
          overflow_d = ovf_d;
        end else begin
          gate_cnt_d = gate_cnt_q - GATE_CNT_W'(1);
        end
      end
      ST_DONE: begin
`ifdef RING_FREQ_METER_AUTORUN_EN
        state_d    = ST_GATE;
        gate_cnt_d = gate_load(gate_sel);
        edge_cnt_d = '0;
        ovf_d      = 1'b0;
        busy_d     = 1'b1;
`else
        state_d    = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Enable low aborts from any state without publishing a result.
    if (!ena) begin
      state_d    = ST_IDLE;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      count_d    = count;
      overflow_d = overflow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_q      <= ovf_d;
      busy       <= busy_d;
      done       <= done_d;
      count      <= count_d;
      overflow   <= overflow_d;
    end
  end

endmodule
